// File: rtl/arc_round_ctrl.sv
// arc_round_ctrl: sequences NR rounds of constant fetch and modular-add execution per job
module arc_round_ctrl #(
    parameter int DW   = 260,
    parameter int NR   = 8,
    parameter int RCAW = 5,
    parameter int TMO  = 64
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic [DW-1:0]   i_x,
    input  logic [DW-1:0]   i_p,
    input  logic [RCAW-1:0] i_rc_base,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [DW-1:0]   o_x,
    output logic            o_rc_rd,
    output logic [RCAW-1:0] o_rc_addr,
    input  logic [DW-1:0]   i_rc_data,
    output logic            o_arc_en,
    output logic [DW-1:0]   o_arc_pre_key,
    output logic [DW-1:0]   o_arc_x,
    output logic [DW-1:0]   o_arc_pos_key,
    output logic [DW-1:0]   o_arc_p,
    input  logic [DW-1:0]   i_arc_res,
    input  logic            i_arc_flag
);
    localparam int RW = $clog2(NR) + 1;
    localparam int TW = $clog2(TMO) + 1;

    typedef enum logic [2:0] {IDLE, RD0, RD1, WPOS, EXEC, DONE, ERR} state_t;

    state_t          state;
    logic [RW-1:0]   round;
    logic [RW-1:0]   round_inc;
    logic [TW-1:0]   tmo;
    logic [RCAW-1:0] base;
    logic [DW-1:0]   p;
    logic [DW-1:0]   pre_key;
    logic [DW-1:0]   pos_key;

    assign round_inc     = round + RW'(1);
    assign o_arc_x       = o_x;
    assign o_arc_p       = p;
    assign o_arc_pre_key = pre_key;
    assign o_arc_pos_key = pos_key;

    // Round FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            round     <= '0;
            tmo       <= '0;
            base      <= '0;
            p         <= '0;
            pre_key   <= '0;
            pos_key   <= '0;
            o_x       <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_rc_rd   <= 1'b0;
            o_rc_addr <= '0;
            o_arc_en  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    o_x       <= i_x;
                    p         <= i_p;
                    base      <= i_rc_base;
                    round     <= '0;
                    o_busy    <= 1'b1;
                    o_rc_rd   <= 1'b1;
                    o_rc_addr <= i_rc_base;
                    state     <= RD0;
                end
                RD0: begin
                    o_rc_addr <= o_rc_addr + RCAW'(1);
                    state     <= RD1;
                end
                RD1: begin
                    pre_key <= i_rc_data;
                    o_rc_rd <= 1'b0;
                    state   <= WPOS;
                end
                WPOS: begin
                    pos_key  <= i_rc_data;
                    tmo      <= '0;
                    o_arc_en <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: if (i_arc_flag) begin
                    // a flag on the last allowed cycle still counts as completion
                    o_x      <= i_arc_res;
                    o_arc_en <= 1'b0;
                    if (round == RW'(NR - 1)) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        round     <= round_inc;
                        o_rc_rd   <= 1'b1;
                        o_rc_addr <= base + RCAW'({round_inc, 1'b0});
                        state     <= RD0;
                    end
                end else if (tmo == TW'(TMO - 1)) begin
                    o_arc_en <= 1'b0;
                    o_done   <= 1'b1;
                    o_err    <= 1'b1;
                    state    <= ERR;
                end else begin
                    tmo <= tmo + TW'(1);
                end
                DONE, ERR: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arc_round_ctrl.sv
// tb_arc_round_ctrl: directed checks of arc_round_ctrl with a constant ROM and modular-add datapath model
module tb_arc_round_ctrl;
    localparam int DW   = 260;
    localparam int NR   = 2;
    localparam int RCAW = 3;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            i_start = 1'b0;
    logic [DW-1:0]   i_x = '0;
    logic [DW-1:0]   i_p = '0;
    logic [RCAW-1:0] i_rc_base = '0;
    logic            o_busy, o_done, o_err, o_rc_rd, o_arc_en;
    logic [DW-1:0]   o_x, o_arc_pre_key, o_arc_x, o_arc_pos_key, o_arc_p;
    logic [RCAW-1:0] o_rc_addr;
    logic [DW-1:0]   rc_data = '0;
    logic [DW-1:0]   arc_res;
    logic            arc_flag;

    logic [DW-1:0]   rom [8];
    logic [DW+1:0]   sum;
    int              exec_cnt = 0;
    int              flag_k = 0;
    int              total = 0;
    int              bad = 0;
    logic [RCAW-1:0] addr_q [$];
    logic [DW-1:0]   first_pre, first_pos, first_p;
    logic [DW-1:0]   p_big;
    int              cyc;
    bit              got_done, got_err;

    arc_round_ctrl #(.DW(DW), .NR(NR), .RCAW(RCAW), .TMO(TMO)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(i_start), .i_x(i_x), .i_p(i_p),
        .i_rc_base(i_rc_base), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_x(o_x), .o_rc_rd(o_rc_rd), .o_rc_addr(o_rc_addr), .i_rc_data(rc_data),
        .o_arc_en(o_arc_en), .o_arc_pre_key(o_arc_pre_key), .o_arc_x(o_arc_x),
        .o_arc_pos_key(o_arc_pos_key), .o_arc_p(o_arc_p), .i_arc_res(arc_res),
        .i_arc_flag(arc_flag)
    );

    always #5 clk = ~clk;

    // ROM answers one cycle after the read strobe
    always @(posedge clk) if (o_rc_rd) rc_data <= rom[o_rc_addr];

    // datapath latency model: flag in the flag_k-th enabled cycle, never when flag_k is 0
    always @(posedge clk) exec_cnt <= o_arc_en ? exec_cnt + 1 : 0;

    always_comb begin
        sum      = {2'b0, o_arc_pre_key} + {2'b0, o_arc_x} + {2'b0, o_arc_pos_key};
        arc_res  = (o_arc_p == '0) ? '0 : DW'(sum % {2'b0, o_arc_p});
        arc_flag = o_arc_en && flag_k != 0 && exec_cnt == flag_k - 1;
    end

    task automatic run_job(input logic [DW-1:0] x, input logic [DW-1:0] p,
                           input logic [RCAW-1:0] base, input int k, input bit poke);
        bit seen_exec = 0;
        flag_k = k;
        addr_q.delete();
        @(negedge clk);
        i_x = x; i_p = p; i_rc_base = base; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        while (!o_done && cyc < 200) begin
            if (o_rc_rd) addr_q.push_back(o_rc_addr);
            if (o_arc_en && !seen_exec) begin
                seen_exec = 1;
                first_pre = o_arc_pre_key; first_pos = o_arc_pos_key; first_p = o_arc_p;
                i_start = poke;
            end else i_start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        got_done = o_done;
        got_err = o_err;
    endtask

    task automatic test_reset;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", o_busy); end
        total++; if (o_done !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL reset_done_err got %0b%0b want 00", o_done, o_err); end
        total++; if (o_x !== '0) begin bad++; $display("FAIL reset_x got %0h want 0", o_x); end
        total++; if (o_rc_rd !== 1'b0 || o_arc_en !== 1'b0 || o_rc_addr !== '0) begin bad++; $display("FAIL reset_ctl got rd=%0b en=%0b addr=%0d want 0 0 0", o_rc_rd, o_arc_en, o_rc_addr); end
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_normal;
        logic [RCAW-1:0] exp_a [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        run_job(DW'(1), p_big, 3'd0, 2, 1'b0);
        total++; if (!got_done || cyc != 11) begin bad++; $display("FAIL normal_latency got done=%0b cycle=%0d want 1 11", got_done, cyc); end
        total++; if (got_err !== 1'b0) begin bad++; $display("FAIL normal_err got %0b want 0", got_err); end
        total++; if (o_x !== DW'(15)) begin bad++; $display("FAIL normal_x got %0h want f", o_x); end
        total++; if (first_pre !== DW'(2) || first_pos !== DW'(3) || first_p !== p_big) begin bad++; $display("FAIL normal_keys got pre=%0h pos=%0h want 2 3", first_pre, first_pos); end
        total++; if (addr_q.size() != 4) begin bad++; $display("FAIL normal_addr_count got %0d want 4", addr_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++; if (addr_q[i] !== exp_a[i]) begin bad++; $display("FAIL normal_addr%0d got %0d want %0d", i, addr_q[i], exp_a[i]); end
        end
        @(negedge clk);
        total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL normal_after got done=%0b busy=%0b want 0 0", o_done, o_busy); end
    endtask

    task automatic test_timeout;
        run_job(DW'(1), p_big, 3'd0, 0, 1'b0);
        total++; if (!got_done || got_err !== 1'b1 || cyc != 12) begin bad++; $display("FAIL timeout_pulse got done=%0b err=%0b cycle=%0d want 1 1 12", got_done, got_err, cyc); end
        total++; if (o_x !== DW'(1)) begin bad++; $display("FAIL timeout_x got %0h want 1", o_x); end
        total++; if (addr_q.size() != 2 || addr_q[0] !== 3'd0 || addr_q[1] !== 3'd1) begin bad++; $display("FAIL timeout_addrs got n=%0d want 2 reads 0,1", addr_q.size()); end
    endtask

    task automatic test_wrap;
        logic [RCAW-1:0] exp_a [4] = '{3'd7, 3'd0, 3'd1, 3'd2};
        rom[7] = DW'(10);
        run_job(DW'(1), DW'(17), 3'd7, 2, 1'b0);
        total++; if (!got_done || got_err || cyc != 11) begin bad++; $display("FAIL wrap_done got done=%0b err=%0b cycle=%0d want 1 0 11", got_done, got_err, cyc); end
        total++; if (o_x !== DW'(3)) begin bad++; $display("FAIL wrap_x got %0h want 3", o_x); end
        total++; if (addr_q.size() != 4) begin bad++; $display("FAIL wrap_addr_count got %0d want 4", addr_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++; if (addr_q[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got %0d want %0d", i, addr_q[i], exp_a[i]); end
        end
    endtask

    task automatic test_start_ignored;
        int extra = 0;
        int busy_seen = 0;
        run_job(DW'(1), p_big, 3'd0, 2, 1'b1);
        total++; if (!got_done || cyc != 11 || o_x !== DW'(15)) begin bad++; $display("FAIL ignore_job got done=%0b cycle=%0d x=%0h want 1 11 f", got_done, cyc, o_x); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (o_done) extra++;
            if (o_busy) busy_seen++;
        end
        total++; if (extra != 0 || busy_seen != 0) begin bad++; $display("FAIL ignore_extra got dones=%0d busy=%0d want 0 0", extra, busy_seen); end
        run_job(DW'(1), p_big, 3'd0, 2, 1'b0);
        total++; if (!got_done || cyc != 11 || o_x !== DW'(15)) begin bad++; $display("FAIL ignore_next got done=%0b cycle=%0d x=%0h want 1 11 f", got_done, cyc, o_x); end
    endtask

    task automatic test_back_to_back;
        run_job(DW'(1), p_big, 3'd0, 1, 1'b0);
        total++; if (!got_done || cyc != 9 || o_x !== DW'(15)) begin bad++; $display("FAIL b2b_first got done=%0b cycle=%0d x=%0h want 1 9 f", got_done, cyc, o_x); end
        run_job(DW'(2), p_big, 3'd0, 1, 1'b0);
        total++; if (!got_done || cyc != 9 || o_x !== DW'(16)) begin bad++; $display("FAIL b2b_second got done=%0b cycle=%0d x=%0h want 1 9 10", got_done, cyc, o_x); end
    endtask

    task automatic test_mid_reset;
        int n = 0;
        int dones = 0;
        int busy_seen = 0;
        flag_k = 0;
        @(negedge clk);
        i_x = DW'(1); i_p = p_big; i_rc_base = 3'd0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (!o_arc_en && n < 20) begin @(negedge clk); n++; end
        total++; if (o_arc_en !== 1'b1 || o_x !== DW'(1)) begin bad++; $display("FAIL midrst_reach got en=%0b x=%0h want 1 1", o_arc_en, o_x); end
        rstn = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0 || o_arc_en !== 1'b0 || o_x !== '0) begin bad++; $display("FAIL midrst_clear got busy=%0b en=%0b x=%0h want 0 0 0", o_busy, o_arc_en, o_x); end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (o_busy) busy_seen++;
        end
        total++; if (dones != 0 || busy_seen != 0) begin bad++; $display("FAIL midrst_quiet got dones=%0d busy=%0d want 0 0", dones, busy_seen); end
        run_job(DW'(1), p_big, 3'd0, 2, 1'b0);
        total++; if (!got_done || got_err || cyc != 11 || o_x !== DW'(15)) begin bad++; $display("FAIL midrst_rerun got done=%0b err=%0b cycle=%0d x=%0h want 1 0 11 f", got_done, got_err, cyc, o_x); end
    endtask

    task automatic test_flag_at_limit;
        run_job(DW'(1), p_big, 3'd0, TMO, 1'b0);
        total++; if (!got_done || got_err !== 1'b0 || cyc != 1 + NR * (3 + TMO)) begin bad++; $display("FAIL limit_done got done=%0b err=%0b cycle=%0d want 1 0 %0d", got_done, got_err, cyc, 1 + NR * (3 + TMO)); end
        total++; if (o_x !== DW'(15)) begin bad++; $display("FAIL limit_x got %0h want f", o_x); end
    endtask

    initial begin
        p_big = '0;
        p_big[DW-1] = 1'b1;
        for (int i = 0; i < 8; i++) rom[i] = '0;
        rom[0] = DW'(2); rom[1] = DW'(3); rom[2] = DW'(4); rom[3] = DW'(5);
        #12;
        test_reset;
        test_normal;
        test_timeout;
        test_back_to_back;
        test_start_ignored;
        test_flag_at_limit;
        test_mid_reset;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
